// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT pipeline constants, stage state type and twiddle stride helper
package fft_pkg;
  localparam int N_FFT = 256;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int tw_stride(int n, int delay);
    return n / (2 * delay);
  endfunction
endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// sdf_stage_ctrl_if: handshake and control bundle between an SDF stage and its controller
interface sdf_stage_ctrl_if #(parameter int TW_W = 7);
  logic in_valid, in_ready, flush, shift_en, bf_sel, tw_en, out_valid, busy;
  logic [TW_W-1:0] tw_addr;
  modport master (output in_valid, flush, input in_ready, shift_en, bf_sel, tw_en, tw_addr, out_valid, busy);
  modport slave (input in_valid, flush, output in_ready, shift_en, bf_sel, tw_en, tw_addr, out_valid, busy);
endinterface

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencing controller for one radix-2 single-path delay-feedback FFT stage
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DELAY = 128,
  parameter int N = N_FFT,
  parameter int CNT_W = $clog2(2 * DELAY),
  parameter int TW_W = $clog2(N / 2)
) (
  input logic clk,
  input logic rst_n,
  sdf_stage_ctrl_if.slave bus
);
  localparam int STRIDE = tw_stride(N, DELAY);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic blk_done_q, blk_done_d, flush_pend_q, flush_pend_d;
  logic shift_en_q, shift_en_d, bf_sel_q, bf_sel_d, out_valid_q, out_valid_d, tw_en_q, tw_en_d;
  logic [TW_W-1:0] tw_addr_q, tw_addr_d;
  logic fp, bnd, in_ready, adv, wrap, dexit;
  always_comb begin
    fp = flush_pend_q | (bus.flush & (state_q != DRAIN));
    bnd = (state_q == RUN) & (cnt_q == '0);
    in_ready = (state_q != DRAIN) & !(bnd & fp);
    adv = (bus.in_valid & in_ready) | (state_q == DRAIN);
    wrap = adv & (cnt_q == CNT_W'(2 * DELAY - 1));
    dexit = (state_q == DRAIN) & (cnt_q == CNT_W'(DELAY - 1));
    cnt_d = dexit ? '0 : adv ? cnt_q + CNT_W'(1) : cnt_q;
    state_d = (state_q == IDLE) ? (adv ? RUN : IDLE) :
              (state_q == RUN) ? ((bnd & fp & blk_done_q) ? DRAIN : RUN) :
              (dexit ? IDLE : DRAIN);
    blk_done_d = !dexit & (blk_done_q | ((state_q == RUN) & wrap));
    flush_pend_d = fp & (((state_q == RUN) & !bnd) | ((state_q == IDLE) & adv));
    shift_en_d = adv;
    bf_sel_d = cnt_q[CNT_W-1];
    out_valid_d = adv & (cnt_q[CNT_W-1] | blk_done_q);
    tw_en_d = adv & !cnt_q[CNT_W-1] & blk_done_q;
    tw_addr_d = tw_en_d ? TW_W'(32'(cnt_q[CNT_W-2:0]) * 32'(STRIDE)) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      blk_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
      shift_en_q <= 1'b0;
      bf_sel_q <= 1'b0;
      out_valid_q <= 1'b0;
      tw_en_q <= 1'b0;
      tw_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      blk_done_q <= blk_done_d;
      flush_pend_q <= flush_pend_d;
      shift_en_q <= shift_en_d;
      bf_sel_q <= bf_sel_d;
      out_valid_q <= out_valid_d;
      tw_en_q <= tw_en_d;
      tw_addr_q <= tw_addr_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.busy = state_q != IDLE;
  assign bus.shift_en = shift_en_q;
  assign bus.bf_sel = bf_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.tw_en = tw_en_q;
  assign bus.tw_addr = tw_addr_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: vector-table and directed-sequence bench for sdf_stage_ctrl
module tb_sdf_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic iv;
    logic fl;
    logic [1:0] c;
    logic [10:0] r;
  } vec_t;
  vec_t vq[$];
  sdf_stage_ctrl_if #(.TW_W(3)) sif();
  sdf_stage_ctrl_if #(.TW_W(7)) lif();
  sdf_stage_ctrl #(.DELAY(4), .N(16)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sif.slave));
  sdf_stage_ctrl dut_l (.clk(clk), .rst_n(rst_n), .bus(lif.slave));
  always #5 clk = ~clk;
  function automatic logic [10:0] rg(logic se, logic bs, logic ov, logic te, int ta);
    return {se, bs, ov, te, 7'(ta)};
  endfunction
  function automatic vec_t mk(logic iv, logic fl, logic rdy, logic bsy, logic se, logic bs, logic ov, logic te, int ta);
    vec_t x;
    x.iv = iv;
    x.fl = fl;
    x.c = {rdy, bsy};
    x.r = rg(se, bs, ov, te, ta);
    return x;
  endfunction
  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [10:0] reg_s();
    return {sif.shift_en, sif.bf_sel, sif.out_valid, sif.tw_en, 4'b0, sif.tw_addr};
  endfunction
  function automatic logic [10:0] reg_l();
    return {lif.shift_en, lif.bf_sel, lif.out_valid, lif.tw_en, lif.tw_addr};
  endfunction
  task automatic step(input logic big, input logic iv, input logic fl, input logic [1:0] c, input logic [10:0] r, input string nm);
    @(negedge clk);
    if (big) begin
      lif.in_valid = iv;
      lif.flush = fl;
    end else begin
      sif.in_valid = iv;
      sif.flush = fl;
    end
    #1;
    chk({nm, ".comb"}, big ? {9'b0, lif.in_ready, lif.busy} : {9'b0, sif.in_ready, sif.busy}, {9'b0, c});
    @(posedge clk);
    #1;
    chk({nm, ".reg"}, big ? reg_l() : reg_s(), r);
  endtask
  initial begin
    rst_n = 1'b0;
    sif.in_valid = 1'b0;
    sif.flush = 1'b0;
    lif.in_valid = 1'b0;
    lif.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_s.comb", {9'b0, sif.in_ready, sif.busy}, 11'b10);
    chk("rst_s.reg", reg_s(), '0);
    chk("rst_l.comb", {9'b0, lif.in_ready, lif.busy}, 11'b10);
    chk("rst_l.reg", reg_l(), '0);
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (3) vq.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 0));
    repeat (2) vq.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++) vq.push_back(mk(1, j == 0, 0, 1, 1, 0, 1, 1, 2 * j));
    vq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (3) vq.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
    repeat (4) vq.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
    for (int j = 0; j < 4; j++) vq.push_back(mk(1, j == 2, 1, 1, 1, 0, 1, 1, 2 * j));
    repeat (4) vq.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++) vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 2 * j));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (3) vq.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
    repeat (4) vq.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++) vq.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, 2 * j));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vq.size(); i++) step(0, vq[i].iv, vq[i].fl, vq[i].c, vq[i].r, $sformatf("vec%0d", i));
    sif.in_valid = 1'b0;
    sif.flush = 1'b0;
    for (int k = 0; k < 77; k++) step(1, 1, 0, {1'b1, k > 0}, rg(1, 0, 0, 0, 0), $sformatf("pre_rst%0d", k));
    @(negedge clk);
    lif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.reg", reg_l(), '0);
    chk("rst_mid.busy", {10'b0, lif.busy}, '0);
    @(posedge clk);
    #1;
    chk("rst_mid_edge.reg", reg_l(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) step(1, 1, 0, {1'b1, k > 0}, rg(1, k >= 128, k >= 128, 0, 0), $sformatf("b1_s%0d", k));
    step(1, 1, 1, 2'b01, '0, "b1_flush_bnd");
    for (int j = 0; j < 128; j++) step(1, 1, 0, 2'b01, rg(1, 0, 1, 1, j), $sformatf("drain1_%0d", j));
    step(1, 0, 0, 2'b10, '0, "idle1");
    for (int k = 0; k < 60; k++) step(1, 1, 0, {1'b1, k > 0}, rg(1, 0, 0, 0, 0), $sformatf("g_s%0d", k));
    for (int g = 0; g < 5; g++) step(1, 0, 0, 2'b11, '0, $sformatf("gap%0d", g));
    for (int k = 60; k < 256; k++) step(1, 1, 0, 2'b11, rg(1, k >= 128, k >= 128, 0, 0), $sformatf("g_s%0d", k));
    for (int k = 0; k < 256; k++) step(1, 1, k == 100, 2'b11, rg(1, k >= 128, 1, k < 128, k < 128 ? k : 0), $sformatf("b2_s%0d", k));
    step(1, 1, 0, 2'b01, '0, "b2_bnd");
    for (int j = 0; j < 128; j++) step(1, 1, 0, 2'b01, rg(1, 0, 1, 1, j), $sformatf("drain2_%0d", j));
    step(1, 1, 0, 2'b10, rg(1, 0, 0, 0, 0), "idle2_accept");
    step(1, 0, 0, 2'b11, '0, "run_after_idle2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
